// File: rtl/network_bf_in_if.sv
// Bank-read / butterfly-operand bundle of the read-side crossbar.
// The master drives issue strobes, selects and bank data; the slave returns operands.
interface network_bf_in_if #(
    parameter int data_width = 12
);
    logic                  in_valid;
    logic [1:0]            sel_b_0;
    logic [1:0]            sel_b_1;
    logic [1:0]            sel_b_2;
    logic [1:0]            sel_b_3;
    logic [data_width-1:0] q0;
    logic [data_width-1:0] q1;
    logic [data_width-1:0] q2;
    logic [data_width-1:0] q3;
    logic [data_width-1:0] bf_0_upper;
    logic [data_width-1:0] bf_0_lower;
    logic [data_width-1:0] bf_1_upper;
    logic [data_width-1:0] bf_1_lower;
    logic                  out_valid;

    modport master (
        output in_valid, sel_b_0, sel_b_1, sel_b_2, sel_b_3, q0, q1, q2, q3,
        input  bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower, out_valid
    );

    modport slave (
        input  in_valid, sel_b_0, sel_b_1, sel_b_2, sel_b_3, q0, q1, q2, q3,
        output bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower, out_valid
    );
endinterface

// File: rtl/network_bf_in.sv
// Read-side crossbar: delays bank selects by the bank read latency, routes q0..q3
// onto the butterfly operands, counts beats per stage and flags bank conflicts.
module network_bf_in #(
    parameter int data_width = 12,
    parameter int RD_LAT     = 1,
    parameter int BEATS      = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    network_bf_in_if.slave           bus,
    input  logic                     clr_err,
    output logic [$clog2(BEATS)-1:0] beat_cnt,
    output logic                     stage_done,
    output logic                     conflict_err
);
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [8:0]            dly_q [RD_LAT];
    logic [8:0]            dly_d [RD_LAT];
    logic                  tap_v;
    logic [1:0]            tap_s [4];
    logic [data_width-1:0] mux [4];
    logic                  conflict;
    logic                  last_beat;

    logic [data_width-1:0] bf_q [4];
    logic [data_width-1:0] bf_d [4];
    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  stage_done_q, stage_done_d;
    logic                  conflict_err_q, conflict_err_d;

    // Stage 0 captures {valid, sel3..sel0}; the last stage lines up with bank data.
    always_comb begin
        dly_d[0] = {bus.in_valid, bus.sel_b_3, bus.sel_b_2, bus.sel_b_1, bus.sel_b_0};
        for (int i = 1; i < RD_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    always_comb begin
        tap_v = dly_q[RD_LAT-1][8];
        for (int j = 0; j < 4; j++) begin
            tap_s[j] = dly_q[RD_LAT-1][2*j +: 2];
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            case (tap_s[j])
                2'd0:    mux[j] = bus.q0;
                2'd1:    mux[j] = bus.q1;
                2'd2:    mux[j] = bus.q2;
                default: mux[j] = bus.q3;
            endcase
        end
    end

    assign conflict = (tap_s[0] == tap_s[1]) || (tap_s[0] == tap_s[2]) ||
                      (tap_s[0] == tap_s[3]) || (tap_s[1] == tap_s[2]) ||
                      (tap_s[1] == tap_s[3]) || (tap_s[2] == tap_s[3]);

    assign last_beat = (beat_cnt_q == LAST_BEAT);

    // A conflict on a delivered beat takes priority over a same-cycle clear.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            bf_d[j] = tap_v ? mux[j] : bf_q[j];
        end
        out_valid_d  = tap_v;
        beat_cnt_d   = beat_cnt_q;
        stage_done_d = 1'b0;
        if (tap_v) begin
            beat_cnt_d   = last_beat ? '0 : beat_cnt_q + 1'b1;
            stage_done_d = last_beat;
        end
        conflict_err_d = conflict_err_q;
        if (tap_v && conflict) begin
            conflict_err_d = 1'b1;
        end else if (clr_err) begin
            conflict_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= '0;
            end
            for (int j = 0; j < 4; j++) begin
                bf_q[j] <= '0;
            end
            out_valid_q    <= 1'b0;
            beat_cnt_q     <= '0;
            stage_done_q   <= 1'b0;
            conflict_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
            for (int j = 0; j < 4; j++) begin
                bf_q[j] <= bf_d[j];
            end
            out_valid_q    <= out_valid_d;
            beat_cnt_q     <= beat_cnt_d;
            stage_done_q   <= stage_done_d;
            conflict_err_q <= conflict_err_d;
        end
    end

    assign bus.bf_0_upper = bf_q[0];
    assign bus.bf_0_lower = bf_q[1];
    assign bus.bf_1_upper = bf_q[2];
    assign bus.bf_1_lower = bf_q[3];
    assign bus.out_valid  = out_valid_q;
    assign beat_cnt       = beat_cnt_q;
    assign stage_done     = stage_done_q;
    assign conflict_err   = conflict_err_q;
endmodule

// File: tb/tb_network_bf_in.sv
// Bench for network_bf_in: scenario tasks compared against a queue-based model
// of issued beats that resolve RD_LAT cycles later against the bank data.
module tb_network_bf_in;
    localparam int DW    = 12;
    localparam int LAT   = 3;
    localparam int BEATS = 128;
    localparam int CW    = $clog2(BEATS);
    localparam int VW    = 3 + CW + 4*DW;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  sels;
    } beat_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          clr_err = 1'b0;
    logic [CW-1:0] beat_cnt;
    logic          stage_done;
    logic          conflict_err;

    int tests_run    = 0;
    int tests_failed = 0;

    network_bf_in_if #(.data_width(DW)) bus ();

    network_bf_in #(.data_width(DW), .RD_LAT(LAT), .BEATS(BEATS)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clr_err      (clr_err),
        .beat_cnt     (beat_cnt),
        .stage_done   (stage_done),
        .conflict_err (conflict_err)
    );

    always #5 clk = ~clk;

    beat_t          pend[$];
    int             mcyc;
    logic [DW-1:0]  exp_op [4];
    logic           exp_valid, exp_done, exp_err;
    int             exp_cnt;

    function automatic logic [DW-1:0] bank(input logic [1:0] s);
        case (s)
            2'd0:    return bus.q0;
            2'd1:    return bus.q1;
            2'd2:    return bus.q2;
            default: return bus.q3;
        endcase
    endfunction

    task automatic model_reset();
        pend.delete();
        mcyc      = 0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_cnt   = 0;
        for (int j = 0; j < 4; j++) exp_op[j] = '0;
    endtask

    // Called at each rising edge: retire the beat whose bank data is present now.
    task automatic model_step();
        beat_t b;
        logic  clash;
        if (!rst) begin
            model_reset();
            return;
        end
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        clash     = 1'b0;
        if (pend.size() > 0 && pend[0].due == mcyc) begin
            b = pend.pop_front();
            for (int j = 0; j < 4; j++) exp_op[j] = bank(b.sels[2*j +: 2]);
            for (int j = 0; j < 4; j++)
                for (int k = j + 1; k < 4; k++)
                    if (b.sels[2*j +: 2] == b.sels[2*k +: 2]) clash = 1'b1;
            exp_valid = 1'b1;
            exp_cnt   = (exp_cnt + 1) % BEATS;
            exp_done  = (exp_cnt == 0);
        end
        if (clash) exp_err = 1'b1;
        else if (clr_err) exp_err = 1'b0;
        if (bus.in_valid) begin
            b.due  = mcyc + LAT;
            b.sels = {bus.sel_b_3, bus.sel_b_2, bus.sel_b_1, bus.sel_b_0};
            pend.push_back(b);
        end
        mcyc++;
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {bus.out_valid, stage_done, conflict_err, beat_cnt,
                bus.bf_0_upper, bus.bf_0_lower, bus.bf_1_upper, bus.bf_1_lower};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_valid, exp_done, exp_err, CW'(exp_cnt),
                exp_op[0], exp_op[1], exp_op[2], exp_op[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus.q0 = DW'($urandom);
        bus.q1 = DW'($urandom);
        bus.q2 = DW'($urandom);
        bus.q3 = DW'($urandom);
    endtask

    // sels packs {sel_b_3, sel_b_2, sel_b_1, sel_b_0}
    task automatic drive(input logic v, input logic [7:0] sels);
        bus.in_valid = v;
        {bus.sel_b_3, bus.sel_b_2, bus.sel_b_1, bus.sel_b_0} = sels;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 8'hE5);
        tick();
        tick();
        tests_run++;
        if (dut_vec() !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h want 0", dut_vec());
        end
        rst = 1'b1;
        drive(1'b0, 8'h00);
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_idle cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_identity();
        drive(1'b1, 8'hE4);
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            if (i == 1) drive(1'b0, 8'h00);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL identity_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
            if (i == LAT) begin
                bus.q0 = 12'h001;
                bus.q1 = 12'h002;
                bus.q2 = 12'h003;
                bus.q3 = 12'h004;
            end
        end
        tests_run++;
        if ({bus.out_valid, conflict_err, beat_cnt, bus.bf_0_upper, bus.bf_0_lower,
             bus.bf_1_upper, bus.bf_1_lower} !==
            {1'b1, 1'b0, CW'(1), 12'h001, 12'h002, 12'h003, 12'h004}) begin
            tests_failed++;
            $display("[TB] FAIL identity_const: got v=%b err=%b cnt=%0d %h %h %h %h want 1 0 1 001 002 003 004",
                     bus.out_valid, conflict_err, beat_cnt, bus.bf_0_upper, bus.bf_0_lower,
                     bus.bf_1_upper, bus.bf_1_lower);
        end
    endtask

    task automatic test_permuted();
        int nvalid, first, last;
        nvalid = 0;
        first  = -1;
        last   = -1;
        for (int i = 0; i < LAT + 8; i++) begin
            drive(i < 4, 8'h1B);
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL permuted_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
            if (bus.out_valid === 1'b1) begin
                nvalid++;
                if (first < 0) first = i;
                last = i;
            end
        end
        drive(1'b0, 8'h00);
        tests_run++;
        if (nvalid != 4 || first != LAT || last != LAT + 3) begin
            tests_failed++;
            $display("[TB] FAIL permuted_timing: got count %0d first %0d last %0d want 4 %0d %0d",
                     nvalid, first, last, LAT, LAT + 3);
        end
    endtask

    task automatic test_stage_wrap();
        int nvalid, ndone, done_at;
        nvalid  = 0;
        ndone   = 0;
        done_at = -1;
        rst = 1'b0;
        model_reset();
        drive(1'b0, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 130 + LAT + 2; i++) begin
            drive(i < 130, 8'($urandom));
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL wrap_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
            if (bus.out_valid === 1'b1) nvalid++;
            if (stage_done === 1'b1) begin
                ndone++;
                done_at = nvalid;
            end
        end
        drive(1'b0, 8'h00);
        tests_run++;
        if (ndone != 1 || done_at != 128 || beat_cnt !== CW'(2) || nvalid != 130) begin
            tests_failed++;
            $display("[TB] FAIL stage_wrap: got done %0d at %0d cnt %0d beats %0d want 1 128 2 130",
                     ndone, done_at, beat_cnt, nvalid);
        end
    endtask

    task automatic test_conflict();
        logic [DW-1:0] q1v;
        q1v     = '0;
        clr_err = 1'b1;
        drive(1'b0, 8'h00);
        tick();
        clr_err = 1'b0;
        tests_run++;
        if (conflict_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_precleared: got %b want 0", conflict_err);
        end
        drive(1'b1, 8'hE5);
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            if (i == 1) drive(1'b0, 8'h00);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL conflict_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
            if (i == LAT) q1v = bus.q1;
        end
        tests_run++;
        if ({bus.out_valid, conflict_err, bus.bf_0_upper, bus.bf_0_lower} !== {1'b1, 1'b1, q1v, q1v}) begin
            tests_failed++;
            $display("[TB] FAIL conflict_rise: got v=%b err=%b %h %h want 1 1 %h %h",
                     bus.out_valid, conflict_err, bus.bf_0_upper, bus.bf_0_lower, q1v, q1v);
        end
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (conflict_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL conflict_sticky: got %b want 1", conflict_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests_run++;
        if (conflict_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL conflict_clear: got %b want 0", conflict_err);
        end
        drive(1'b1, 8'hE5);
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            if (i == 1) drive(1'b0, 8'h00);
            clr_err = (i == LAT);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL setwins_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if (conflict_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL set_wins: got %b want 1", conflict_err);
        end
    endtask

    task automatic test_no_valid();
        int nvalid;
        nvalid  = 0;
        clr_err = 1'b1;
        drive(1'b0, 8'h00);
        tick();
        clr_err = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            drive(1'b0, (i % 2 == 0) ? 8'h00 : 8'hE5);
            tick();
            if (bus.out_valid === 1'b1) nvalid++;
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL novalid_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if (nvalid != 0 || conflict_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL novalid_quiet: got valids %0d err %b want 0 0", nvalid, conflict_err);
        end
    endtask

    task automatic test_reset_midstream();
        int nvalid;
        nvalid = 0;
        drive(1'b1, 8'($urandom));
        tick();
        drive(1'b1, 8'($urandom));
        tick();
        drive(1'b0, 8'h00);
        rst = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (dut_vec() !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got %h want 0", dut_vec());
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            if (bus.out_valid === 1'b1) nvalid++;
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL dropped_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if (nvalid != 0) begin
            tests_failed++;
            $display("[TB] FAIL dropped_beats: got %0d valids want 0", nvalid);
        end
        drive(1'b1, 8'hE4);
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            if (i == 1) drive(1'b0, 8'h00);
        end
        tests_run++;
        if ({bus.out_valid, beat_cnt} !== {1'b1, CW'(1)}) begin
            tests_failed++;
            $display("[TB] FAIL cnt_restart: got v=%b cnt=%0d want 1 1", bus.out_valid, beat_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400 + LAT + 2; i++) begin
            if (i < 400) begin
                drive($urandom_range(0, 9) < 7, 8'($urandom));
                clr_err = ($urandom_range(0, 19) == 0);
            end else begin
                drive(1'b0, 8'h00);
                clr_err = 1'b0;
            end
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("[TB] FAIL random_model cyc %0d: got %h want %h", mcyc, dut_vec(), exp_vec());
            end
        end
        clr_err = 1'b0;
    endtask

    initial begin
        model_reset();
        drive(1'b0, 8'h00);
        bus.q0 = '0;
        bus.q1 = '0;
        bus.q2 = '0;
        bus.q3 = '0;
        test_reset();
        test_identity();
        test_permuted();
        test_stage_wrap();
        test_conflict();
        test_no_valid();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
